// File: rtl/rr_dispatcher_pkg.sv
// Shared helpers for the round-robin dispatcher: index sizing and the
// cyclic "first available slot at or after the pointer" picker.
package rr_dispatcher_pkg;

    localparam int MaxOut  = 32;
    localparam int PickBits = 5;

    typedef logic [PickBits-1:0] pick_t;

    function automatic int idxWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Search the bits at or above ptr first (thermometer mask), then fall
    // back to the unmasked vector so the search wraps from the top to bit 0.
    function automatic pick_t rrPick(input logic [MaxOut-1:0] avail,
                                     input pick_t             ptr);
        logic [MaxOut-1:0] mask;
        logic [MaxOut-1:0] masked;
        pick_t             pick;
        logic              found;
        mask   = {MaxOut{1'b1}} << ptr;
        masked = avail & mask;
        pick   = '0;
        found  = 1'b0;
        for (int i = 0; i < MaxOut; i++) begin
            if (!found && masked[i]) begin
                pick  = pick_t'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < MaxOut; i++) begin
            if (!found && avail[i]) begin
                pick  = pick_t'(i);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_dispatcher_slot.sv
// One-entry output buffer of the dispatcher: valid bit, payload register
// and the "can accept this cycle" indication (empty or draining now).
module DispatchSlot #(
    parameter int dataWidth = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 i_load,
    input  logic [dataWidth-1:0] i_loadData,
    input  logic                 i_outReady,
    output logic                 o_valid,
    output logic [dataWidth-1:0] o_data,
    output logic                 o_avail
);

    logic                 r_valid;
    logic [dataWidth-1:0] r_data;

    // Clear wins over a reload; a reload wins over a plain drain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_outReady) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (i_load) begin
            r_data <= i_loadData;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_avail = !r_valid || i_outReady;

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher: each accepted upstream item goes to the first
// available output slot at or after a rotating pointer.
module rr_dispatcher
    import rr_dispatcher_pkg::*;
#(
    parameter int nOut      = 4,
    parameter int dataWidth = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [dataWidth-1:0]      in_data,
    output logic [nOut-1:0]           out_valid,
    input  logic [nOut-1:0]           out_ready,
    output logic [nOut*dataWidth-1:0] out_data,
    output logic [idxWidth(nOut)-1:0] last_slot
);

    localparam int IW = idxWidth(nOut);

    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_last;
    logic [nOut-1:0] w_avail;
    logic [IW-1:0]   w_sel;
    logic            w_accept;

    // in_ready is gated by reset_n so it reads low while reset is held.
    assign w_sel    = IW'(rrPick(MaxOut'(w_avail), PickBits'(r_ptr)));
    assign in_ready = (|w_avail) && !clear && reset_n;
    assign w_accept = in_valid && in_ready;

    for (genvar i = 0; i < nOut; i++) begin : gSlot
        DispatchSlot #(
            .dataWidth (dataWidth)
        ) uSlot (
            .clock      (clock),
            .reset_n    (reset_n),
            .clear      (clear),
            .i_load     (w_accept && (w_sel == IW'(i))),
            .i_loadData (in_data),
            .i_outReady (out_ready[i]),
            .o_valid    (out_valid[i]),
            .o_data     (out_data[i*dataWidth +: dataWidth]),
            .o_avail    (w_avail[i])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr  <= '0;
            r_last <= '0;
        end else if (clear) begin
            r_ptr  <= '0;
        end else if (w_accept) begin
            r_ptr  <= (w_sel == IW'(nOut - 1)) ? '0 : w_sel + 1'b1;
            r_last <= w_sel;
        end
    end

    assign last_slot = r_last;

endmodule

// File: tb/tb_rr_dispatcher.sv
// Self-checking bench for rr_dispatcher (4 ports, 8-bit payload): directed
// vector table, reset corner cases and randomized traffic against a model.
module tb_rr_dispatcher;

    logic        clock;
    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [1:0]  last_slot;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: per-port queue of depth one plus pointer and last index.
    logic [3:0] mValid;
    logic [7:0] mData [4];
    int         mPtr;
    int         mLast;

    typedef struct packed {
        logic        preReset;
        logic        inValid;
        logic [7:0]  inData;
        logic [3:0]  outReady;
        logic        clr;
        logic        expRdy;
        logic [3:0]  expOv;
        logic [31:0] expData;
        logic [1:0]  expLast;
    } vec_t;

    vec_t tbl [29];

    rr_dispatcher #(
        .nOut      (4),
        .dataWidth (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .last_slot (last_slot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic pre, input logic v, input logic [7:0] d,
                                   input logic [3:0] r, input logic c, input logic rdy,
                                   input logic [3:0] ov, input logic [31:0] dat,
                                   input logic [1:0] last);
        vec_t x;
        x.preReset = pre; x.inValid = v; x.inData = d; x.outReady = r; x.clr = c;
        x.expRdy = rdy; x.expOv = ov; x.expData = dat; x.expLast = last;
        return x;
    endfunction

    function automatic logic [31:0] laneMask(input logic [3:0] ov);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (ov[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic [3:0] r, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        mValid = '0;
        mPtr   = 0;
        mLast  = 0;
    endtask

    // Expected behaviour derived from the rules: a slot takes an item if it is
    // empty or draining; the first such slot scanning from the pointer wins.
    task automatic advance();
        logic [3:0] nValid;
        logic [7:0] nData [4];
        int         nPtr;
        int         nLast;
        int         pick;
        logic       acc;
        nValid = mValid;
        nData  = mData;
        nPtr   = mPtr;
        nLast  = mLast;
        if (reset_n) begin
            pick = -1;
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (mPtr + k) % 4;
                if (pick < 0 && (!mValid[idx] || out_ready[idx])) pick = idx;
            end
            acc = in_valid && (pick >= 0) && !clear;
            if (clear) begin
                nValid = '0;
                nPtr   = 0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (acc && i == pick) begin
                        nValid[i] = 1'b1;
                        nData[i]  = in_data;
                    end else if (out_ready[i]) begin
                        nValid[i] = 1'b0;
                    end
                end
                if (acc) begin
                    nPtr  = (pick + 1) % 4;
                    nLast = pick;
                end
            end
        end
        @(posedge clock);
        mValid = nValid;
        mData  = nData;
        mPtr   = nPtr;
        mLast  = nLast;
        @(negedge clock);
    endtask

    task automatic checkModel();
        logic        expRdy;
        logic [31:0] expData;
        expRdy = 1'b0;
        for (int i = 0; i < 4; i++) if (!mValid[i] || out_ready[i]) expRdy = 1'b1;
        expRdy = expRdy && !clear;
        for (int i = 0; i < 4; i++) expData[i*8 +: 8] = mData[i];
        checkOutput("rnd in_ready", 32'(in_ready), 32'(expRdy));
        checkOutput("rnd out_valid", 32'(out_valid), 32'(mValid));
        checkOutput("rnd out_data", out_data & laneMask(mValid), expData & laneMask(mValid));
        checkOutput("rnd last_slot", 32'(last_slot), 32'(mLast));
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 4'h0, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        resetModel();
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 4'h0, 1'b0);
        resetModel();
        for (int i = 0; i < 4; i++) mData[i] = 8'h00;

        // Back-to-back dispatch with every consumer ready.
        tbl[0]  = mkVec(1, 1, 8'h10, 4'hF, 0, 1, 4'b0000, 32'h00000000, 0);
        tbl[1]  = mkVec(0, 1, 8'h11, 4'hF, 0, 1, 4'b0001, 32'h00000010, 0);
        tbl[2]  = mkVec(0, 1, 8'h12, 4'hF, 0, 1, 4'b0010, 32'h00001100, 1);
        tbl[3]  = mkVec(0, 1, 8'h13, 4'hF, 0, 1, 4'b0100, 32'h00120000, 2);
        tbl[4]  = mkVec(0, 1, 8'h14, 4'hF, 0, 1, 4'b1000, 32'h13000000, 3);
        tbl[5]  = mkVec(0, 1, 8'h15, 4'hF, 0, 1, 4'b0001, 32'h00000014, 0);
        tbl[6]  = mkVec(0, 0, 8'h00, 4'hF, 0, 1, 4'b0010, 32'h00001500, 1);
        tbl[7]  = mkVec(0, 0, 8'h00, 4'hF, 0, 1, 4'b0000, 32'h00000000, 1);
        // Fill with consumers stalled, then backpressure and single-port refill.
        tbl[8]  = mkVec(1, 1, 8'h20, 4'h0, 0, 1, 4'b0000, 32'h00000000, 0);
        tbl[9]  = mkVec(0, 1, 8'h21, 4'h0, 0, 1, 4'b0001, 32'h00000020, 0);
        tbl[10] = mkVec(0, 1, 8'h22, 4'h0, 0, 1, 4'b0011, 32'h00002120, 1);
        tbl[11] = mkVec(0, 1, 8'h23, 4'h0, 0, 1, 4'b0111, 32'h00222120, 2);
        tbl[12] = mkVec(0, 1, 8'h24, 4'h0, 0, 0, 4'b1111, 32'h23222120, 3);
        tbl[13] = mkVec(0, 1, 8'h24, 4'h0, 0, 0, 4'b1111, 32'h23222120, 3);
        tbl[14] = mkVec(0, 1, 8'hAA, 4'h8, 0, 1, 4'b1111, 32'h23222120, 3);
        tbl[15] = mkVec(0, 0, 8'h00, 4'h0, 0, 0, 4'b1111, 32'hAA222120, 3);
        tbl[16] = mkVec(0, 0, 8'h00, 4'h3, 0, 1, 4'b1111, 32'hAA222120, 3);
        tbl[17] = mkVec(0, 0, 8'h00, 4'h0, 0, 1, 4'b1100, 32'hAA220000, 3);
        // Clear with an offered item and two full slots.
        tbl[18] = mkVec(0, 1, 8'h55, 4'h0, 1, 0, 4'b1100, 32'hAA220000, 3);
        tbl[19] = mkVec(0, 0, 8'h00, 4'h0, 0, 1, 4'b0000, 32'h00000000, 3);
        tbl[20] = mkVec(0, 1, 8'h66, 4'h0, 0, 1, 4'b0000, 32'h00000000, 3);
        tbl[21] = mkVec(0, 0, 8'h00, 4'h0, 0, 1, 4'b0001, 32'h00000066, 0);
        // Stalled port 1 with pointer at 1: item skips to port 2, then port 3.
        tbl[22] = mkVec(0, 1, 8'h71, 4'h0, 0, 1, 4'b0001, 32'h00000066, 0);
        tbl[23] = mkVec(0, 1, 8'h72, 4'h0, 0, 1, 4'b0011, 32'h00007166, 1);
        tbl[24] = mkVec(0, 1, 8'h73, 4'h0, 0, 1, 4'b0111, 32'h00727166, 2);
        tbl[25] = mkVec(0, 1, 8'h74, 4'h1, 0, 1, 4'b1111, 32'h73727166, 3);
        tbl[26] = mkVec(0, 1, 8'h75, 4'hD, 0, 1, 4'b1111, 32'h73727174, 0);
        tbl[27] = mkVec(0, 1, 8'h76, 4'hD, 0, 1, 4'b0110, 32'h00757100, 2);
        tbl[28] = mkVec(0, 0, 8'h00, 4'h0, 0, 1, 4'b1010, 32'h76007100, 3);

        @(negedge clock);
        #1;
        checkOutput("reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset last_slot", 32'(last_slot), 32'h0);
        checkOutput("reset in_ready", 32'(in_ready), 32'h0);
        @(negedge clock);

        for (int k = 0; k < 29; k++) begin
            if (tbl[k].preReset) doReset();
            applyStimulus(tbl[k].inValid, tbl[k].inData, tbl[k].outReady, tbl[k].clr);
            #1;
            checkOutput($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'(tbl[k].expRdy));
            checkOutput($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(tbl[k].expOv));
            checkOutput($sformatf("vec%0d out_data", k), out_data & laneMask(tbl[k].expOv),
                        tbl[k].expData & laneMask(tbl[k].expOv));
            checkOutput($sformatf("vec%0d last_slot", k), 32'(last_slot), 32'(tbl[k].expLast));
            advance();
        end

        // Asynchronous reset pulse between edges with items buffered.
        doReset();
        applyStimulus(1'b1, 8'h31, 4'h0, 1'b0);
        #1; checkModel(); advance();
        applyStimulus(1'b1, 8'h32, 4'h0, 1'b0);
        #1; checkModel(); advance();
        applyStimulus(1'b0, 8'h00, 4'h0, 1'b0);
        #1; checkModel();
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async rst out_valid", 32'(out_valid), 32'h0);
        checkOutput("async rst in_ready", 32'(in_ready), 32'h0);
        checkOutput("async rst last_slot", 32'(last_slot), 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        resetModel();
        applyStimulus(1'b1, 8'h99, 4'h0, 1'b0);
        #1;
        checkOutput("post rst in_ready", 32'(in_ready), 32'h1);
        advance();
        applyStimulus(1'b0, 8'h00, 4'h0, 1'b0);
        #1;
        checkOutput("post rst out_valid", 32'(out_valid), 32'h1);
        checkOutput("post rst out_data", 32'(out_data[7:0]), 32'h99);
        checkOutput("post rst last_slot", 32'(last_slot), 32'h0);
        advance();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom),
                          $urandom_range(0, 19) == 0);
            #1;
            checkModel();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
